wave_capture: RTL and testbench

Upstream stage of the grid/waveform renderer. Captures 12-bit microphone samples on each rising edge of `clk_sample` into a 1280-column waveform buffer, using a rising-edge trigger with auto-timeout. During the VGA scan it reads the buffer back and drives `wave_cond`, the per-pixel "waveform here" flag the renderer uses to paint the trace. Consecutive samples are joined with vertical segments so the trace is continuous.

---
 rtl/wave_capture.sv | 155 +++++++++++++++
 tb/tb_wave_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// Captures a synchronized sample stream into a column buffer (trigger or auto-timeout)
// and replays it as a per-pixel trace flag during the VGA scan, joining adjacent columns.
module wave_capture #(
    parameter int H_COLS       = 1280,
    parameter int V_ROWS       = 1024,
    parameter int TRIG_LEVEL   = 2048,
    parameter int TRIG_TIMEOUT = 4096
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        clk_sample,
    input  logic [11:0] MIC_in,
    input  logic        freeze,
    input  logic [11:0] VGA_HORZ_COORD,
    input  logic [11:0] VGA_VERT_COORD,
    output logic        wave_cond,
    output logic        capturing,
    output logic        triggered
);

    localparam int AW = $clog2(H_COLS);
    localparam int TW = $clog2(TRIG_TIMEOUT + 1);
    localparam logic [11:0]   TRIG_L   = 12'(TRIG_LEVEL);
    localparam logic [11:0]   H_LIM    = 12'(H_COLS);
    localparam logic [11:0]   V_LIM    = 12'(V_ROWS);
    localparam logic [AW-1:0] H_LAST   = AW'(H_COLS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TRIG_TIMEOUT - 1);

    typedef enum logic [1:0] {ARMED, FILL, HOLD} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync_q;
    logic          tick, tick_d1_q;
    logic [11:0]   cur_q, prev_q;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic          pend_q, pend_d;
    logic          triggered_q, triggered_d;
    logic          we, trig_hit, frame_start;
    logic [9:0]    row;

    assign tick        = sync_q[1] & ~sync_q[2];
    assign row         = 10'd1023 - cur_q[11:2];
    assign trig_hit    = tick_d1_q && (prev_q < TRIG_L) && (cur_q >= TRIG_L);
    assign frame_start = (VGA_HORZ_COORD == 12'd0) && (VGA_VERT_COORD == 12'd0);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q      <= '0;
            tick_d1_q   <= 1'b0;
            cur_q       <= '0;
            prev_q      <= '0;
            state_q     <= ARMED;
            wptr_q      <= '0;
            tmo_q       <= '0;
            valid_q     <= 1'b0;
            pend_q      <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], clk_sample};
            tick_d1_q <= tick;
            if (tick) begin
                cur_q  <= MIC_in;
                prev_q <= cur_q;
            end
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            tmo_q       <= tmo_d;
            valid_q     <= valid_d;
            pend_q      <= pend_d;
            triggered_q <= triggered_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        tmo_d       = tmo_q;
        valid_d     = valid_q;
        pend_d      = pend_q;
        triggered_d = triggered_q;
        we          = 1'b0;
        case (state_q)
            ARMED: begin
                // tmo saturates so a long freeze cannot wrap it past the timeout
                if (tick && tmo_q != TMO_LAST) tmo_d = tmo_q + TW'(1);
                if (!freeze) begin
                    if (trig_hit) begin
                        state_d = FILL;
                        pend_d  = 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = FILL;
                        pend_d  = 1'b0;
                    end
                end
            end
            FILL: begin
                if (tick_d1_q) begin
                    we = 1'b1;
                    if (wptr_q == H_LAST) begin
                        wptr_d      = '0;
                        valid_d     = 1'b1;
                        triggered_d = pend_q;
                        state_d     = HOLD;
                    end else begin
                        wptr_d = wptr_q + AW'(1);
                    end
                end
            end
            HOLD: begin
                if (frame_start && !freeze) begin
                    tmo_d   = '0;
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    // Display pipeline: stage 1 reads the RAM, stage 2 joins with the previous column.
    logic [9:0]    mem_q [H_COLS];
    logic [9:0]    q_q, qp_q, qa, lo, hi;
    logic [AW-1:0] rd_addr;
    logic [11:0]   x1_q, y1_q;
    logic          wave_q, wave_d;

    assign rd_addr = (VGA_HORZ_COORD < H_LIM) ? VGA_HORZ_COORD[AW-1:0] : '0;

    always_ff @(posedge CLK) begin
        if (we) mem_q[wptr_q] <= row;
        q_q  <= mem_q[rd_addr];
        qp_q <= q_q;
        x1_q <= VGA_HORZ_COORD;
        y1_q <= VGA_VERT_COORD;
    end

    always_comb begin
        qa     = (x1_q == 12'd0) ? q_q : qp_q;
        lo     = (q_q < qa) ? q_q : qa;
        hi     = (q_q < qa) ? qa : q_q;
        wave_d = valid_q && (x1_q < H_LIM) && (y1_q < V_LIM) &&
                 ({2'b00, lo} <= y1_q) && (y1_q <= {2'b00, hi});
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) wave_q <= 1'b0;
        else         wave_q <= wave_d;
    end

    assign wave_cond = wave_q;
    assign capturing = (state_q == FILL);
    assign triggered = triggered_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed/random bench for wave_capture: a sample-level model of capture and a
// per-pixel model of the trace flag are compared against the DUT.
module tb_wave_capture;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        clk_sample;
    logic [11:0] MIC_in;
    logic        freeze;
    logic [11:0] hx, vy;
    logic        wave_cond, capturing, triggered;

    always #5 CLK = ~CLK;

    wave_capture dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .clk_sample     (clk_sample),
        .MIC_in         (MIC_in),
        .freeze         (freeze),
        .VGA_HORZ_COORD (hx),
        .VGA_VERT_COORD (vy),
        .wave_cond      (wave_cond),
        .capturing      (capturing),
        .triggered      (triggered)
    );

    int checks = 0;
    int errors = 0;

    // model: mode 0 = waiting for trigger/timeout, 1 = filling, 2 = holding
    int mbuf [1280];
    int m_mode, m_tmo, m_wptr, m_valid, m_pend, m_trig, m_prev, m_cur;
    int exq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_tmo = 0; m_wptr = 0; m_valid = 0;
        m_pend = 0; m_trig = 0; m_prev = 0; m_cur = 0;
    endtask

    task automatic m_tick(input int s);
        m_prev = m_cur;
        m_cur  = s;
        if (m_mode == 1) begin
            mbuf[m_wptr] = 1023 - (s / 4);
            m_wptr++;
            if (m_wptr == 1280) begin
                m_wptr = 0; m_valid = 1; m_trig = m_pend; m_mode = 2;
            end
        end else if (m_mode == 0) begin
            if (m_tmo < 4095) m_tmo++;
            if (!freeze) begin
                if (m_prev < 2048 && m_cur >= 2048) begin
                    m_mode = 1; m_pend = 1;
                end else if (m_tmo == 4095) begin
                    m_mode = 1; m_pend = 0;
                end
            end
        end
    endtask

    task automatic m_frame();
        if (m_mode == 2 && !freeze) begin
            m_mode = 0; m_tmo = 0;
        end
    endtask

    function automatic int expect_wave(input int x, input int y, input int px);
        int qv, qp, lo, hi;
        if (m_valid == 0 || x >= 1280 || y >= 1024) return 0;
        qv = mbuf[x];
        if (x == 0) qp = qv;
        else if (px < 1280) qp = mbuf[px];
        else return -1;
        lo = (qv < qp) ? qv : qp;
        hi = (qv < qp) ? qp : qv;
        return (y >= lo && y <= hi) ? 1 : 0;
    endfunction

    task automatic do_tick(input int s);
        hx = 12'd5; vy = 12'd5;
        MIC_in = 12'(s);
        clk_sample = 1'b1;
        repeat (3) @(posedge CLK);
        #1 clk_sample = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        m_tick(s);
        check("capturing", 32'(capturing), (m_mode == 1) ? 1 : 0);
        check("triggered", 32'(triggered), m_trig);
    endtask

    task automatic scan(input int x0, input int n, input int y);
        int e, x, px;
        for (int i = 0; i < n + 2; i++) begin
            @(posedge CLK);
            #1;
            if (i >= 2) begin
                e = exq.pop_front();
                if (e >= 0) check("wave_cond", 32'(wave_cond), e);
            end
            if (i < n) begin
                x  = x0 + i;
                px = int'(hx);
                hx = 12'(x);
                vy = 12'(y);
                if (x == 0 && y == 0) m_frame();
                exq.push_back(expect_wave(x, y, px));
            end
        end
    endtask

    task automatic reset_pulse();
        @(posedge CLK);
        #3 RESETN = 1'b0;
        #1;
        check("rst_wave", 32'(wave_cond), 0);
        check("rst_cap",  32'(capturing), 0);
        check("rst_trig", 32'(triggered), 0);
        m_reset();
        repeat (2) @(posedge CLK);
        #1 RESETN = 1'b1;
    endtask

    task automatic random_scans(input int k);
        for (int j = 0; j < k; j++)
            scan($urandom_range(0, 1200), 64, $urandom_range(0, 1023));
    endtask

    initial begin
        int guard;
        RESETN = 1'b0; clk_sample = 1'b0; MIC_in = '0; freeze = 1'b0;
        hx = 12'd5; vy = 12'd5;
        for (int i = 0; i < 1280; i++) mbuf[i] = 0;
        m_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_wave", 32'(wave_cond), 0);
        check("rst_cap",  32'(capturing), 0);
        check("rst_trig", 32'(triggered), 0);
        RESETN = 1'b1;
        scan(0, 40, $urandom_range(1, 1023));
        reset_pulse();
        scan(100, 40, $urandom_range(0, 1023));

        // rising crossing 2000 -> 3000 starts a triggered capture
        do_tick(0); do_tick(1000); do_tick(2000); do_tick(3000);
        repeat (1280) do_tick(3000);
        scan(0, 1280, 273);
        scan(0, 64, 272);
        scan(600, 64, 274);
        random_scans(4);

        // untriggered capture after the timeout
        scan(0, 1, 0);
        repeat (4095 + 1280) do_tick(100);
        scan(0, 1280, 998);
        random_scans(4);

        // alternating extremes: adjacent columns span the full height
        scan(0, 1, 0);
        for (int i = 0; i < 1282; i++) do_tick((i % 2) ? 4095 : 0);
        scan(0, 1280, 1023);
        scan(0, 1280, 500);
        scan(0, 1280, 0);
        random_scans(3);

        // random capture with freeze raised mid-fill
        scan(0, 1, 0);
        guard = 0;
        while (m_mode != 1 && guard < 3000) begin
            do_tick($urandom_range(0, 4095)); guard++;
        end
        repeat (600) do_tick($urandom_range(0, 4095));
        freeze = 1'b1;
        guard = 0;
        while (m_mode == 1 && guard < 1000) begin
            do_tick($urandom_range(0, 4095)); guard++;
        end
        for (int f = 0; f < 3; f++) begin
            scan(0, 1, 0);
            repeat (4) do_tick($urandom_range(0, 4095));
            scan(0, 1, 0);
            do_tick(0); do_tick(4095);
            random_scans(2);
        end

        // blanking region
        scan(1280, 408, $urandom_range(0, 1023));
        for (int y = 1024; y < 1066; y += 7) scan($urandom_range(0, 1200), 16, y);

        freeze = 1'b0;
        do_tick(0); do_tick(4095);
        scan(0, 1, 0);
        do_tick(0); do_tick(4095);

        // reset during fill discards the partial capture
        repeat (100) do_tick($urandom_range(0, 4095));
        reset_pulse();
        scan(0, 64, $urandom_range(0, 1023));
        do_tick(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
